bin2bcd_7seg_seq: RTL and testbench
===================================

Name: bin2bcd_7seg_seq

Overview:
Parametrised, sequential binary-to-7-segment converter for N-bit unsigned inputs driving DIGITS displays. It uses iterative double-dabble: one shift per clock, with a start/busy/done handshake. Results are registered and held until the next conversion completes. It sits between switch/datapath sources and the board's active-low 7-segment displays, and replaces the combinational 10-bit/4-digit converter.

Parameters:
N, 10, input binary width (>=1)
DIGITS, 4, number of BCD digits / 7-seg displays (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  conversion request, sampled only in IDLE
A  input  N  unsigned binary value, captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new results are valid
ovf  output  1  value > 10^DIGITS-1 for the last completed conversion
bcd  output  4*DIGITS  packed BCD, digit k (k=0 is units) at [4k+3:4k]
seg  output  7*DIGITS  active-low segments, digit k at [7k+6:7k]; within each field bit 6 = a ... bit 0 = g

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, ovf=0, bcd=0; every seg field = 7'b1111111 (all off). An in-flight conversion is aborted and its result discarded.
- FSM states: IDLE, CONV, UPDATE.
- IDLE: if start=1, capture A into the shift register, clear the BCD accumulator and the overflow flag, load counter=N, then go to CONV. busy=1 starting the next cycle.
- CONV: each cycle, add 3 to every BCD nibble >=5, then shift {bcd_acc, bin} left by 1 and decrement the counter. A 1 shifted out of the top nibble sets the internal overflow flag (sticky for this conversion). When the counter reaches 0, go to UPDATE.
- UPDATE: register bcd, ovf, and seg. Pulse done=1 for exactly this cycle. busy=0 from the next cycle. Return to IDLE.
- Latency: start accepted at edge 0 -> done high after edge N+1. Back-to-back: a start asserted during the done cycle is ignored; start is accepted again from IDLE on the following cycle.
- start while busy: ignored. A changes while busy: no effect.
- Segment codes (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- ovf=1: every seg field shows a dash (1111110). bcd holds the truncated low DIGITS digits.
- Outputs are stable between done pulses. There is no combinational path from A or start to any output.

Optional Feature:
Macro BIN2BCD_LZB_EN.
- Defined: leading-zero blanking. Any digit above the most-significant nonzero digit shows 1111111. The units digit is always shown (value 0 -> "   0"). ovf dashes take precedence over blanking. bcd is unaffected.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
- Reset then idle -> busy=0, done=0, ovf=0, bcd=0, all seg fields 1111111. Assert rst mid-CONV -> same values immediately, no done pulse.
- N=10, DIGITS=4, A=1023, start pulse -> done exactly N+1=11 cycles later; bcd=16'h1023; seg digits 3..0 = 1001111, 0000001, 0010010, 0000110; ovf=0.
- A=0, then A=999 back-to-back -> first result bcd=0, all fields 0000001; second bcd=16'h0999, digit 3 = 0000001, digits 2..0 = 0000100.
- start held high and A toggled during CONV -> exactly one done per accepted start; result matches A at capture; each done followed by one idle cycle before the next accept.
- N=10, DIGITS=3, A=1000 -> ovf=1, bcd=12'h000, all fields 1111110. A=999 -> ovf=0, bcd=12'h999.
- BIN2BCD_LZB_EN defined, DIGITS=4, A=7 -> digits 3..1 = 1111111, digit 0 = 0001111. A=0 -> only digit 0 lit (0000001).

Source files
------------

// File: rtl/bin2bcd_7seg_seq.sv
// Sequential double-dabble converter: N-bit unsigned value -> DIGITS packed BCD digits plus
// active-low 7-segment fields, one shift per clock. Define BIN2BCD_LZB_EN for leading-zero blanking.
module bin2bcd_7seg_seq #(
  parameter int N      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          A,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    bin_q, bin_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            oacc_q, oacc_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [SW-1:0]   seg_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction applied before every shift.
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  // Display image of the finished accumulator; dashes override any blanking.
`ifdef BIN2BCD_LZB_EN
  logic lead;
`endif
  always_comb begin
    seg_nxt = '1;
`ifdef BIN2BCD_LZB_EN
    lead = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (oacc_q) begin
        seg_nxt[7*k +: 7] = 7'b1111110;
      end
`ifdef BIN2BCD_LZB_EN
      else if (lead && (acc_q[4*k +: 4] == 4'd0) && (k != 0)) begin
        seg_nxt[7*k +: 7] = 7'b1111111;
      end else begin
        lead              = 1'b0;
        seg_nxt[7*k +: 7] = seg_code(acc_q[4*k +: 4]);
      end
`else
      else begin
        seg_nxt[7*k +: 7] = seg_code(acc_q[4*k +: 4]);
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    oacc_d  = oacc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE; a start seen then is deliberately dropped.
        if (start && !done_q) begin
          bin_d   = A;
          acc_d   = '0;
          oacc_d  = 1'b0;
          cnt_d   = CW'(N);
          state_d = CONV;
        end
      end
      CONV: begin
        oacc_d = oacc_q | adj[BW-1];
        acc_d  = {adj[BW-2:0], bin_q[N-1]};
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        bcd_d   = acc_q;
        ovf_d   = oacc_q;
        seg_d   = seg_nxt;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      oacc_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      oacc_q  <= oacc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bin2bcd_7seg_seq.sv
// Scoreboard bench for bin2bcd_7seg_seq: a 4-digit and a 3-digit instance, both N=10.
module tb_bin2bcd_7seg_seq;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start4, start3;
  logic [N-1:0]  a4, a3;
  logic          busy4, done4, ovf4, busy3, done3, ovf3;
  logic [15:0]   bcd4;
  logic [27:0]   seg4;
  logic [11:0]   bcd3;
  logic [20:0]   seg3;

  bin2bcd_7seg_seq #(.N(N), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4),
    .busy(busy4), .done(done4), .ovf(ovf4), .bcd(bcd4), .seg(seg4)
  );

  bin2bcd_7seg_seq #(.N(N), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .A(a3),
    .busy(busy3), .done(done3), .ovf(ovf3), .bcd(bcd3), .seg(seg3)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [27:0] seg;
    int          t;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   asserts = 0;
  int   fails   = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] code(input logic [3:0] d);
    case (d)
      4'd0: code = 7'b0000001;  4'd1: code = 7'b1001111;
      4'd2: code = 7'b0010010;  4'd3: code = 7'b0000110;
      4'd4: code = 7'b1001100;  4'd5: code = 7'b0100100;
      4'd6: code = 7'b0100000;  4'd7: code = 7'b0001111;
      4'd8: code = 7'b0000000;  4'd9: code = 7'b0000100;
      default: code = 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] model_seg(input logic [15:0] b, input logic o, input int nd);
    logic [27:0] s;
    logic        lead;
    logic [3:0]  d;
    s    = '1;
    lead = 1'b1;
    for (int k = nd - 1; k >= 0; k--) begin
      d = b[4*k +: 4];
      if (o) s[7*k +: 7] = 7'b1111110;
`ifdef BIN2BCD_LZB_EN
      else if (lead && d == 4'd0 && k != 0) s[7*k +: 7] = 7'b1111111;
      else begin
        lead = 1'b0;
        s[7*k +: 7] = code(d);
      end
`else
      else s[7*k +: 7] = code(d);
`endif
    end
    return s;
  endfunction

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL dut4 unexpected done at cycle %0d: got done=1, expected none", cyc);
      end else begin
        e = q4.pop_front();
        check("dut4 bcd", 32'(bcd4), 32'(e.bcd));
        check("dut4 ovf", 32'(ovf4), 32'(e.ovf));
        check("dut4 seg", 32'(seg4), 32'(e.seg));
        check("dut4 latency cycle", 32'(cyc), 32'(e.t));
        check("dut4 busy in done cycle", 32'(busy4), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done3) begin
      if (q3.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL dut3 unexpected done at cycle %0d: got done=1, expected none", cyc);
      end else begin
        e = q3.pop_front();
        check("dut3 bcd", 32'(bcd3), 32'(e.bcd[11:0]));
        check("dut3 ovf", 32'(ovf3), 32'(e.ovf));
        check("dut3 seg", 32'(seg3), 32'(e.seg[20:0]));
        check("dut3 latency cycle", 32'(cyc), 32'(e.t));
      end
    end
  end

  // Issue one conversion (called at a negedge), corrupt A while busy, then wait for done
  // plus one idle cycle so the next call is accepted back-to-back.
  task automatic conv(input int sel, input logic [N-1:0] a, input logic [15:0] b, input logic o);
    exp_t e;
    bit   seen;
    e.bcd = b;
    e.ovf = o;
    e.seg = model_seg(b, o, (sel == 4) ? 4 : 3);
    e.t   = cyc + N + 2;
    if (sel == 4) begin q4.push_back(e); a4 = a; start4 = 1'b1; end
    else          begin q3.push_back(e); a3 = a; start3 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start3 = 1'b0;
    a4 = ~a;
    a3 = ~a;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (sel == 4) ? done4 : done3;
    end
    if (!seen) begin
      asserts++;
      fails++;
      $display("FAIL dut%0d done timeout: got no done in 40 cycles, expected one", sel);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst    = 1'b1;
    start4 = 1'b0;
    start3 = 1'b0;
    a4     = '0;
    a3     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("reset busy",  32'(busy4), 32'd0);
    check("reset done",  32'(done4), 32'd0);
    check("reset ovf",   32'(ovf4),  32'd0);
    check("reset bcd",   32'(bcd4),  32'd0);
    check("reset seg4",  32'(seg4),  32'h0fffffff);
    check("reset seg3",  32'(seg3),  32'h001fffff);

    conv(4, 10'd1023, 16'h1023, 1'b0);
    conv(4, 10'd0,    16'h0000, 1'b0);
    conv(4, 10'd999,  16'h0999, 1'b0);
    conv(4, 10'd7,    16'h0007, 1'b0);
    conv(4, 10'd512,  16'h0512, 1'b0);
    conv(4, 10'd100,  16'h0100, 1'b0);
    conv(4, 10'd1,    16'h0001, 1'b0);

    conv(3, 10'd1000, 16'h0000, 1'b1);
    conv(3, 10'd999,  16'h0999, 1'b0);
    conv(3, 10'd1023, 16'h0023, 1'b1);
    conv(3, 10'd5,    16'h0005, 1'b0);
    conv(3, 10'd1000, 16'h0000, 1'b1);

    // start held through the done cycle with A scrambled every cycle:
    // accepts land 13 cycles apart, capturing 345 then 88.
    for (int i = 0; i < 30; i++) begin
      start4 = (i <= 13);
      if (i == 0) begin
        a4 = 10'd345;
        e.bcd = 16'h0345; e.ovf = 1'b0; e.seg = model_seg(16'h0345, 1'b0, 4); e.t = cyc + N + 2;
        q4.push_back(e);
      end else if (i == 13) begin
        a4 = 10'd88;
        e.bcd = 16'h0088; e.ovf = 1'b0; e.seg = model_seg(16'h0088, 1'b0, 4); e.t = cyc + N + 2;
        q4.push_back(e);
      end else begin
        a4 = 10'(i * 37 + 500);
      end
      @(negedge clk);
    end
    start4 = 1'b0;

    // Abort mid-conversion: outputs return to reset values at once, no done follows.
    a4 = 10'd500;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy",  32'(busy4), 32'd0);
    check("abort done",  32'(done4), 32'd0);
    check("abort bcd",   32'(bcd4),  32'd0);
    check("abort seg4",  32'(seg4),  32'h0fffffff);
    check("abort ovf3",  32'(ovf3),  32'd0);
    check("abort seg3",  32'(seg3),  32'h001fffff);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort still idle", 32'(busy4), 32'd0);

    conv(4, 10'd42, 16'h0042, 1'b0);

    check("dut4 queue drained", 32'(q4.size()), 32'd0);
    check("dut3 queue drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
